h264_mm2s_mb_fetch_ctrl: RTL and testbench

//  Sequences reads from the MM2S async-FIFO read port (H264_ACLK side) and frames the raw 64-bit word stream into macroblocks.

---
 rtl/h264_mm2s_mb_fetch_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_h264_mm2s_mb_fetch_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/h264_mm2s_mb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : h264_mm2s_mb_fetch_ctrl
// Purpose  : Pops 64-bit words from the MM2S async-FIFO read port and frames
//            them into macroblocks (Y 16x16, then Cb 8x8, then Cr 8x8) in
//            raster order, one frame per start pulse.
// Ports    : H264_ACLK / H264_ARESETN  - clock, async active-low reset
//            start_i, mb_width_i, mb_height_i - frame launch and dimensions
//            busy_o, frame_done_o       - frame status
//            H264_RVALID_I/RDATA_I/RREADY_O - show-ahead FIFO read port
//            mb_valid_o/mb_ready_i/mb_data_o/mb_comp_o/mb_first_o/mb_last_o/
//            mb_x_o/mb_y_o/frame_last_o - framed output stream
//            stats_clr_i, stall_cnt_o   - FIFO starvation counter, present
//                                         only with H264_FETCH_STATS_EN
// Config   : H264_FETCH_STATS_EN (optional starvation statistics)
// Revision : 1.0 - initial release
// ============================================================================
module h264_mm2s_mb_fetch_ctrl #(
    parameter int MBW_W   = 8,
    parameter int MBH_W   = 8,
    parameter int Y_WORDS = 32,
    parameter int C_WORDS = 8
) (
    input  logic              H264_ACLK,
    input  logic              H264_ARESETN,
    input  logic              start_i,
    input  logic [MBW_W-1:0]  mb_width_i,
    input  logic [MBH_W-1:0]  mb_height_i,
    output logic              busy_o,
    output logic              frame_done_o,
    input  logic              H264_RVALID_I,
    input  logic [63:0]       H264_RDATA_I,
    output logic              H264_RREADY_O,
`ifdef H264_FETCH_STATS_EN
    input  logic              stats_clr_i,
    output logic [31:0]       stall_cnt_o,
`endif
    output logic              mb_valid_o,
    input  logic              mb_ready_i,
    output logic [63:0]       mb_data_o,
    output logic [1:0]        mb_comp_o,
    output logic              mb_first_o,
    output logic              mb_last_o,
    output logic [MBW_W-1:0]  mb_x_o,
    output logic [MBH_W-1:0]  mb_y_o,
    output logic              frame_last_o
);

    localparam int CNT_W = $clog2((Y_WORDS > C_WORDS) ? Y_WORDS : C_WORDS);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(Y_WORDS - 1);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(C_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [MBW_W-1:0] X_ONE   = {{(MBW_W-1){1'b0}}, 1'b1};
    localparam logic [MBH_W-1:0] Y_ONE   = {{(MBH_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH_Y  = 3'd1,
        S_FETCH_CB = 3'd2,
        S_FETCH_CR = 3'd3,
        S_DRAIN    = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [MBW_W-1:0]   width_q;
    logic [MBH_W-1:0]   height_q;
    logic [MBW_W-1:0]   x_cnt;
    logic [MBH_W-1:0]   y_cnt;
    logic [CNT_W-1:0]   word_cnt;
    logic               zero_done;

    logic               fetch;
    logic               pop;
    logic               comp_end;
    logic               last_mb;
    logic               dims_ok;
    logic               launch;
    logic [1:0]         comp_cur;

    // ------------------------------------------------------------------------
    // Next-state and combinational outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        fetch     = (state == S_FETCH_Y) || (state == S_FETCH_CB) ||
                    (state == S_FETCH_CR);
        // Pop whenever the output register is empty or being drained this
        // cycle, so back-to-back words flow at one per clock.
        H264_RREADY_O = fetch && (!mb_valid_o || mb_ready_i);
        pop       = H264_RREADY_O && H264_RVALID_I;
        comp_end  = (state == S_FETCH_Y) ? (word_cnt == Y_LAST)
                                         : (word_cnt == C_LAST);
        last_mb   = (x_cnt == width_q - X_ONE) && (y_cnt == height_q - Y_ONE);
        dims_ok   = (|mb_width_i) && (|mb_height_i);
        launch    = (state == S_IDLE) && start_i && dims_ok;
        comp_cur  = 2'd0;
        if (state == S_FETCH_CB) comp_cur = 2'd1;
        if (state == S_FETCH_CR) comp_cur = 2'd2;

        case (state)
            S_IDLE:     if (launch) state_nxt = S_FETCH_Y;
            S_FETCH_Y:  if (pop && comp_end) state_nxt = S_FETCH_CB;
            S_FETCH_CB: if (pop && comp_end) state_nxt = S_FETCH_CR;
            S_FETCH_CR: if (pop && comp_end)
                            state_nxt = last_mb ? S_DRAIN : S_FETCH_Y;
            S_DRAIN:    if (!mb_valid_o) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase

        busy_o       = (state != S_IDLE);
        // Frame completion: either the drain finishes (same cycle as the
        // return to IDLE) or a degenerate zero-sized start was seen.
        frame_done_o = ((state == S_DRAIN) && !mb_valid_o) || zero_done;
    end

    always_ff @(posedge H264_ACLK or negedge H264_ARESETN) begin
        if (!H264_ARESETN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Counters, latched dimensions and the single-register output stage
    // ------------------------------------------------------------------------
    always_ff @(posedge H264_ACLK or negedge H264_ARESETN) begin
        if (!H264_ARESETN) begin
            width_q      <= '0;
            height_q     <= '0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            word_cnt     <= '0;
            zero_done    <= 1'b0;
            mb_valid_o   <= 1'b0;
            mb_data_o    <= '0;
            mb_comp_o    <= 2'd0;
            mb_first_o   <= 1'b0;
            mb_last_o    <= 1'b0;
            mb_x_o       <= '0;
            mb_y_o       <= '0;
            frame_last_o <= 1'b0;
        end else begin
            zero_done <= (state == S_IDLE) && start_i && !dims_ok;

            if (launch) begin
                width_q  <= mb_width_i;
                height_q <= mb_height_i;
                x_cnt    <= '0;
                y_cnt    <= '0;
                word_cnt <= '0;
            end

            if (pop) begin
                mb_valid_o   <= 1'b1;
                mb_data_o    <= H264_RDATA_I;
                mb_comp_o    <= comp_cur;
                mb_first_o   <= (state == S_FETCH_Y) && (word_cnt == '0);
                mb_last_o    <= (state == S_FETCH_CR) && comp_end;
                frame_last_o <= (state == S_FETCH_CR) && comp_end && last_mb;
                mb_x_o       <= x_cnt;
                mb_y_o       <= y_cnt;
                if (comp_end) begin
                    word_cnt <= '0;
                    // MB position advances only once Cr is complete.
                    if (state == S_FETCH_CR) begin
                        if (x_cnt == width_q - X_ONE) begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + Y_ONE;
                        end else begin
                            x_cnt <= x_cnt + X_ONE;
                        end
                    end
                end else begin
                    word_cnt <= word_cnt + CNT_ONE;
                end
            end else if (mb_ready_i) begin
                mb_valid_o <= 1'b0;
            end
        end
    end

`ifdef H264_FETCH_STATS_EN
    // ------------------------------------------------------------------------
    // FIFO starvation counter: fetching, nothing buffered, nothing arriving.
    // ------------------------------------------------------------------------
    logic [31:0] stall_cnt;

    always_ff @(posedge H264_ACLK or negedge H264_ARESETN) begin
        if (!H264_ARESETN) begin
            stall_cnt <= 32'd0;
        end else if (stats_clr_i) begin
            stall_cnt <= 32'd0;
        end else if (fetch && !H264_RVALID_I && !mb_valid_o &&
                     (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_h264_mm2s_mb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_h264_mm2s_mb_fetch_ctrl
// Purpose  : Self-checking bench for h264_mm2s_mb_fetch_ctrl. Frames are
//            described in a table; every output word is checked against an
//            index-based macroblock model, plus hand-written corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_h264_mm2s_mb_fetch_ctrl;

    localparam int MBW_W = 8;
    localparam int MBH_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic [MBW_W-1:0]  mb_width_i = '0;
    logic [MBH_W-1:0]  mb_height_i = '0;
    logic              busy_o;
    logic              frame_done_o;
    logic              rvalid = 1'b0;
    logic [63:0]       rdata = '0;
    logic              rready;
    logic              mb_valid_o;
    logic              mb_ready_i = 1'b0;
    logic [63:0]       mb_data_o;
    logic [1:0]        mb_comp_o;
    logic              mb_first_o;
    logic              mb_last_o;
    logic [MBW_W-1:0]  mb_x_o;
    logic [MBH_W-1:0]  mb_y_o;
    logic              frame_last_o;
`ifdef H264_FETCH_STATS_EN
    logic              stats_clr_i = 1'b0;
    logic [31:0]       stall_cnt_o;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    h264_mm2s_mb_fetch_ctrl #(
        .MBW_W(MBW_W), .MBH_W(MBH_W), .Y_WORDS(32), .C_WORDS(8)
    ) dut (
        .H264_ACLK     (clk),
        .H264_ARESETN  (rst_n),
        .start_i       (start_i),
        .mb_width_i    (mb_width_i),
        .mb_height_i   (mb_height_i),
        .busy_o        (busy_o),
        .frame_done_o  (frame_done_o),
        .H264_RVALID_I (rvalid),
        .H264_RDATA_I  (rdata),
        .H264_RREADY_O (rready),
`ifdef H264_FETCH_STATS_EN
        .stats_clr_i   (stats_clr_i),
        .stall_cnt_o   (stall_cnt_o),
`endif
        .mb_valid_o    (mb_valid_o),
        .mb_ready_i    (mb_ready_i),
        .mb_data_o     (mb_data_o),
        .mb_comp_o     (mb_comp_o),
        .mb_first_o    (mb_first_o),
        .mb_last_o     (mb_last_o),
        .mb_x_o        (mb_x_o),
        .mb_y_o        (mb_y_o),
        .frame_last_o  (frame_last_o)
    );

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [84:0] out_pack();
        return {mb_data_o, mb_comp_o, mb_first_o, mb_last_o, mb_x_o, mb_y_o,
                frame_last_o};
    endfunction

    function automatic logic [88:0] all_outputs();
        return {busy_o, frame_done_o, rready, mb_valid_o, mb_data_o, mb_comp_o,
                mb_first_o, mb_last_o, mb_x_o, mb_y_o, frame_last_o};
    endfunction

    // Reference: the i-th word of a frame is fully described by i alone.
    function automatic logic [84:0] model_word(input logic [63:0] base,
                                               input int i, input int w,
                                               input int total);
        int mb  = i / 48;
        int ofs = i % 48;
        logic [1:0] comp = (ofs < 32) ? 2'd0 : ((ofs < 40) ? 2'd1 : 2'd2);
        return {base + 64'(i), comp, (ofs == 0), (ofs == 47),
                8'(mb % w), 8'(mb / w), (i == total - 1)};
    endfunction

    function automatic logic src_valid(input int mode);
        if (mode == 1) return ($urandom % 4) != 0;
        if (mode == 2) return ($urandom % 2) != 0;
        return 1'b1;
    endfunction

    // mode 0: full rate; 1: ready toggles, RVALID gaps; 2: both random.
    task automatic run_frame(input int w, input int h, input int mode,
                             input int abort_at, input int inject,
                             output int n_words, output int lx, output int ly);
        logic [63:0] base = {$urandom, $urandom};
        int total = w * h * 48;
        int src = 0, got = 0, cyc = 0, done_cnt = 0;
        int first_cyc = -1, last_cyc = -1, exp_stall = 0;
        int budget = total * 30 + 200;
        bit stalled = 0, pop_now, aborted = 0;
        logic [84:0] prev = '0;
        lx = -1; ly = -1;

`ifdef H264_FETCH_STATS_EN
        @(posedge clk); #1; stats_clr_i = 1'b1;
        @(posedge clk); #1; stats_clr_i = 1'b0;
        chk("stall_clr", 128'(stall_cnt_o), 128'd0);
`endif
        @(posedge clk); #1;
        mb_width_i = 8'(w); mb_height_i = 8'(h); start_i = 1'b1;
        rdata = base; rvalid = src_valid(mode);
        mb_ready_i = (mode == 0) ? 1'b1 : 1'($urandom);
        @(posedge clk); #1;
        start_i = 1'b0;
        mb_width_i = 8'($urandom); mb_height_i = 8'($urandom);

        forever begin
            @(negedge clk);
            cyc++;
            if (cyc > budget) begin
                chk("frame_timeout", 128'(got), 128'(total));
                break;
            end
            if (stalled) chk("stall_stable", 128'(out_pack()), 128'(prev));
            if (abort_at >= 0 && mb_valid_o && got == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("async_reset_outputs", 128'(all_outputs()), 128'd0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                aborted = 1;
                break;
            end
            if (busy_o && src < total && !rvalid && !mb_valid_o) exp_stall++;
            if (frame_done_o) begin
                done_cnt++;
                chk("frame_done_timing", 128'((got == total) && (cyc == last_cyc + 1)), 128'd1);
            end
            if (mb_valid_o && mb_ready_i) begin
                chk("word", 128'(out_pack()), 128'(model_word(base, got, w, total)));
                if (got == 0) first_cyc = cyc;
                last_cyc = cyc;
                lx = int'(mb_x_o); ly = int'(mb_y_o);
                got++;
            end
            pop_now = rvalid && rready;
            stalled = mb_valid_o && !mb_ready_i;
            prev    = out_pack();
            if (frame_done_o) break;
            @(posedge clk); #1;
            if (pop_now) src++;
            rdata  = base + 64'(src);
            rvalid = src_valid(mode);
            if (mode == 0)      mb_ready_i = 1'b1;
            else if (mode == 1) mb_ready_i = ~mb_ready_i;
            else                mb_ready_i = ($urandom % 3) != 0;
            start_i = (inject != 0) && (cyc == 20);
            if (start_i) begin
                mb_width_i = 8'd1; mb_height_i = 8'd1;
            end
        end

        if (!aborted) begin
            chk("frame_done_count", 128'(done_cnt), 128'd1);
            if (mode == 0) chk("full_rate", 128'(last_cyc - first_cyc), 128'(total - 1));
`ifdef H264_FETCH_STATS_EN
            chk("stall_cnt", 128'(stall_cnt_o), 128'(exp_stall));
`endif
            @(negedge clk);
            chk("idle_after_frame", 128'({busy_o, frame_done_o}), 128'd0);
        end
        n_words = got;
        rvalid = 1'b0;
        mb_ready_i = 1'b0;
    endtask

    typedef struct {
        int w; int h; int mode; int abort_at; int inject;
        int exp_words; int exp_lx; int exp_ly;
    } vec_t;

    initial begin
        vec_t tbl[7];
        int n, lx, ly;

        tbl[0] = '{1, 1, 0, -1, 0,  48, 0, 0};
        tbl[1] = '{3, 2, 0, -1, 0, 288, 2, 1};
        tbl[2] = '{3, 2, 1, -1, 0, 288, 2, 1};
        tbl[3] = '{2, 3, 2, -1, 1, 288, 1, 2};
        tbl[4] = '{4, 1, 2, -1, 0, 192, 3, 0};
        tbl[5] = '{1, 2, 1, -1, 0,  96, 0, 1};
        tbl[6] = '{2, 1, 0, 68, 0,  68, 1, 0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 128'(all_outputs()), 128'd0);
`ifdef H264_FETCH_STATS_EN
        chk("reset_stall_cnt", 128'(stall_cnt_o), 128'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i].w, tbl[i].h, tbl[i].mode, tbl[i].abort_at,
                      tbl[i].inject, n, lx, ly);
            chk("frame_words", 128'(n), 128'(tbl[i].exp_words));
            chk("last_mb_xy", 128'({lx[7:0], ly[7:0]}),
                128'({8'(tbl[i].exp_lx), 8'(tbl[i].exp_ly)}));
        end

        // After the mid-frame reset, a fresh frame restarts at (0,0), Y.
        run_frame(1, 1, 0, -1, 0, n, lx, ly);
        chk("restart_words", 128'(n), 128'd48);

        // Zero-sized frames: done next cycle, never busy, never pops.
        for (int z = 0; z < 2; z++) begin
            @(posedge clk); #1;
            rvalid = 1'b1;
            mb_width_i  = (z == 0) ? 8'd0 : 8'd3;
            mb_height_i = (z == 0) ? 8'd4 : 8'd0;
            start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
            @(negedge clk);
            chk("zero_dim_done", 128'({frame_done_o, busy_o, rready}), 128'b100);
            @(negedge clk);
            chk("zero_dim_after", 128'({frame_done_o, busy_o, rready}), 128'b000);
            rvalid = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
